// File: rtl/ace_resp_pkg.sv
// Shared encodings and FSM state types for the ACE memory responder.
package ace_resp_pkg;

    localparam logic [3:0] AR_READ_NO_SNOOP = 4'b0000;
    localparam logic [3:0] AR_READ_SHARED   = 4'b0001;
    localparam logic [3:0] AR_MAKE_UNIQUE   = 4'b1100;

    localparam logic [2:0] AW_WRITE_NO_SNOOP = 3'b000;
    localparam logic [2:0] AW_WRITE_CLEAN    = 3'b010;
    localparam logic [2:0] AW_WRITE_BACK     = 3'b011;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    function automatic logic ar_snoop_ok(input logic [3:0] snoop);
        return (snoop == AR_READ_NO_SNOOP) || (snoop == AR_READ_SHARED) ||
               (snoop == AR_MAKE_UNIQUE);
    endfunction

    function automatic logic aw_snoop_ok(input logic [2:0] snoop);
        return (snoop == AW_WRITE_NO_SNOOP) || (snoop == AW_WRITE_CLEAN) ||
               (snoop == AW_WRITE_BACK);
    endfunction

endpackage

// File: rtl/ace_resp_ram.sv
// Backing store: one synchronous write port, one registered read-first read port.
module ace_resp_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Both updates are non-blocking, so a colliding read sees the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ace_mem_responder.sv
// ACE memory/home-agent responder: AR/R and AW/W/B channels over a word-addressed RAM.
module ace_mem_responder
    import ace_resp_pkg::*;
#(
    parameter int unsigned WIDTH_A = 32,
    parameter int unsigned WIDTH_D = 32,
    parameter int unsigned DEPTH   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               AW_VALID,
    output logic               AW_READY,
    input  logic [WIDTH_A-1:0] AW_ADDR,
    input  logic               AW_ID,
    input  logic [7:0]         AW_LEN,
    input  logic [2:0]         AW_SNOOP,
    input  logic               W_VALID,
    output logic               W_READY,
    input  logic               W_LAST,
    input  logic [WIDTH_D-1:0] W_DATA,
    output logic               B_VALID,
    input  logic               B_READY,
    output logic [1:0]         BRESP,
    output logic               B_ID,
    input  logic               AR_VALID,
    output logic               AR_READY,
    input  logic [WIDTH_A-1:0] AR_ADDR,
    input  logic               AR_ID,
    input  logic [7:0]         AR_LEN,
    input  logic [3:0]         AR_SNOOP,
    output logic               R_VALID,
    input  logic               R_READY,
    output logic               R_ID,
    output logic               R_LAST,
    output logic [3:0]         RRESP,
    output logic [WIDTH_D-1:0] RDATA,
    input  logic               peer_shared
);

    localparam int unsigned IDX = $clog2(DEPTH);

    // ---------------- read side ----------------
    rd_state_t    rd_state_q;
    logic         rd_id_q, rd_mem_q;
    logic [7:0]   rd_len_q, rd_cnt_q;
    logic [IDX-1:0] rd_idx_q;
    logic [3:0]   rd_resp_q;

    logic [IDX-1:0] ar_idx, ram_raddr;
    logic         ar_dec, ar_mu, ar_rd, ar_hs, r_hs, rd_last, ram_re;
    logic [1:0]   ar_code;
    logic [WIDTH_D-1:0] ram_rdata;

    assign ar_idx  = AR_ADDR[IDX+1:2];
    assign ar_dec  = |AR_ADDR[WIDTH_A-1:IDX+2];
    assign ar_mu   = (AR_SNOOP == AR_MAKE_UNIQUE);
    assign ar_rd   = !ar_dec && !ar_mu && ar_snoop_ok(AR_SNOOP);
    assign ar_code = ar_dec ? RESP_DECERR : (ar_snoop_ok(AR_SNOOP) ? RESP_OKAY : RESP_SLVERR);
    assign ar_hs   = AR_VALID && AR_READY;
    assign r_hs    = R_VALID && R_READY;
    assign rd_last = (rd_cnt_q == rd_len_q);

    // Fetch the next word only when a beat is consumed, so stalled data stays put.
    assign ram_re    = (ar_hs && ar_rd) || (r_hs && !rd_last && rd_mem_q);
    assign ram_raddr = (rd_state_q == RD_IDLE) ? ar_idx : rd_idx_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            rd_id_q    <= 1'b0;
            rd_mem_q   <= 1'b0;
            rd_len_q   <= 8'd0;
            rd_cnt_q   <= 8'd0;
            rd_idx_q   <= '0;
            rd_resp_q  <= 4'd0;
        end else begin
            unique case (rd_state_q)
                RD_IDLE: if (AR_VALID) begin
                    rd_state_q <= RD_BURST;
                    rd_id_q    <= AR_ID;
                    rd_mem_q   <= ar_rd;
                    rd_len_q   <= ar_mu ? 8'd0 : AR_LEN;
                    rd_cnt_q   <= 8'd0;
                    rd_idx_q   <= ar_idx;
                    rd_resp_q  <= {(AR_SNOOP == AR_READ_SHARED) && peer_shared && !ar_dec,
                                   1'b0, ar_code};
                end
                RD_BURST: if (R_READY) begin
                    if (rd_last) begin
                        rd_state_q <= RD_IDLE;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 8'd1;
                        rd_idx_q <= rd_idx_q + 1'b1;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign AR_READY = (rd_state_q == RD_IDLE);
    assign R_VALID  = (rd_state_q == RD_BURST);
    assign R_LAST   = R_VALID && rd_last;
    assign R_ID     = rd_id_q;
    assign RRESP    = rd_resp_q;
    assign RDATA    = (R_VALID && rd_mem_q) ? ram_rdata : '0;

    // ---------------- write side ----------------
    wr_state_t    wr_state_q;
    logic         wr_id_q, wr_dec_q, wr_bad_q, wr_err_q;
    logic [7:0]   wr_len_q, wr_cnt_q;
    logic [IDX-1:0] wr_idx_q;
    logic [1:0]   bresp_q;
    logic         aw_dec, w_hs, wr_last, last_err, ram_we;

    assign aw_dec   = |AW_ADDR[WIDTH_A-1:IDX+2];
    assign w_hs     = W_VALID && W_READY;
    assign wr_last  = (wr_cnt_q == wr_len_q);
    assign last_err = (W_LAST != wr_last);
    assign ram_we   = w_hs && !wr_dec_q && !wr_bad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            wr_id_q    <= 1'b0;
            wr_dec_q   <= 1'b0;
            wr_bad_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            wr_len_q   <= 8'd0;
            wr_cnt_q   <= 8'd0;
            wr_idx_q   <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            unique case (wr_state_q)
                WR_IDLE: if (AW_VALID) begin
                    wr_state_q <= WR_DATA;
                    wr_id_q    <= AW_ID;
                    wr_dec_q   <= aw_dec;
                    wr_bad_q   <= !aw_snoop_ok(AW_SNOOP);
                    wr_err_q   <= 1'b0;
                    wr_len_q   <= AW_LEN;
                    wr_cnt_q   <= 8'd0;
                    wr_idx_q   <= AW_ADDR[IDX+1:2];
                end
                WR_DATA: if (W_VALID) begin
                    wr_err_q <= wr_err_q || last_err;
                    if (wr_last) begin
                        wr_state_q <= WR_RESP;
                        if (wr_dec_q) bresp_q <= RESP_DECERR;
                        else if (wr_bad_q || wr_err_q || last_err) bresp_q <= RESP_SLVERR;
                        else bresp_q <= RESP_OKAY;
                    end else begin
                        wr_cnt_q <= wr_cnt_q + 8'd1;
                        wr_idx_q <= wr_idx_q + 1'b1;
                    end
                end
                WR_RESP: if (B_READY) wr_state_q <= WR_IDLE;
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    assign AW_READY = (wr_state_q == WR_IDLE);
    assign W_READY  = (wr_state_q == WR_DATA);
    assign B_VALID  = (wr_state_q == WR_RESP);
    assign BRESP    = bresp_q;
    assign B_ID     = wr_id_q;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{AR_ADDR[1:0], AW_ADDR[1:0]};

    ace_resp_ram #(
        .WIDTH(WIDTH_D),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (ram_we),
        .waddr_i(wr_idx_q),
        .wdata_i(W_DATA),
        .re_i   (ram_re),
        .raddr_i(ram_raddr),
        .rdata_o(ram_rdata)
    );

endmodule

// File: tb/tb_ace_mem_responder.sv
// Directed self-checking bench for ace_mem_responder; inputs change and outputs are sampled on negedge.
module tb_ace_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        AW_VALID, AW_READY, AW_ID;
    logic [31:0] AW_ADDR;
    logic [7:0]  AW_LEN;
    logic [2:0]  AW_SNOOP;
    logic        W_VALID, W_READY, W_LAST;
    logic [31:0] W_DATA;
    logic        B_VALID, B_READY, B_ID;
    logic [1:0]  BRESP;
    logic        AR_VALID, AR_READY, AR_ID;
    logic [31:0] AR_ADDR;
    logic [7:0]  AR_LEN;
    logic [3:0]  AR_SNOOP;
    logic        R_VALID, R_READY, R_ID, R_LAST;
    logic [3:0]  RRESP;
    logic [31:0] RDATA;
    logic        peer_shared;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [256];

    always #5 clk = ~clk;

    ace_mem_responder #(.WIDTH_A(32), .WIDTH_D(32), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_ID(AW_ID),
        .AW_LEN(AW_LEN), .AW_SNOOP(AW_SNOOP),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_LAST(W_LAST), .W_DATA(W_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .BRESP(BRESP), .B_ID(B_ID),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_ID(AR_ID),
        .AR_LEN(AR_LEN), .AR_SNOOP(AR_SNOOP),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_ID(R_ID), .R_LAST(R_LAST),
        .RRESP(RRESP), .RDATA(RDATA), .peer_shared(peer_shared)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] snoop, input logic id, input logic [31:0] base,
                            input int last_at, input logic commit, input logic [1:0] exp_bresp);
        logic [7:0] wi;
        check({tag, "_awready"}, AW_READY, 1);
        AW_VALID = 1; AW_ADDR = addr; AW_LEN = len; AW_SNOOP = snoop; AW_ID = id;
        @(negedge clk);
        AW_VALID = 0;
        check({tag, "_awready_busy"}, AW_READY, 0);
        for (int i = 0; i <= int'(len); i++) begin
            W_VALID = 1; W_DATA = base + 32'(i); W_LAST = (i == last_at);
            check({tag, "_wready"}, W_READY, 1);
            @(negedge clk);
            if (commit) begin
                wi = addr[9:2] + 8'(i);
                model[wi] = base + 32'(i);
            end
        end
        W_VALID = 0; W_LAST = 0;
        check({tag, "_bvalid"}, B_VALID, 1);
        check({tag, "_bresp"}, BRESP, exp_bresp);
        check({tag, "_bid"}, B_ID, id);
        @(negedge clk);
        check({tag, "_bresp_hold"}, BRESP, exp_bresp);
        B_READY = 1;
        @(negedge clk);
        B_READY = 0;
        check({tag, "_bvalid_done"}, B_VALID, 0);
        check({tag, "_awready_back"}, AW_READY, 1);
    endtask

    task automatic rd_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [3:0] snoop, input logic peer, input logic id,
                            input logic toggle, input int nbeats, input logic [3:0] exp_resp,
                            input logic exp_mem);
        logic [7:0]  ri;
        logic [31:0] expd;
        check({tag, "_arready"}, AR_READY, 1);
        AR_VALID = 1; AR_ADDR = addr; AR_LEN = len; AR_SNOOP = snoop; AR_ID = id;
        peer_shared = peer; R_READY = 1;
        @(negedge clk);
        AR_VALID = 0; peer_shared = 0;
        check({tag, "_arready_busy"}, AR_READY, 0);
        for (int b = 0; b < nbeats; b++) begin
            ri = addr[9:2] + 8'(b);
            expd = exp_mem ? model[ri] : 32'd0;
            if (toggle && b > 0) begin
                R_READY = 0;
                check({tag, "_rdata_pre"}, RDATA, expd);
                @(negedge clk);
                check({tag, "_rvalid_stall"}, R_VALID, 1);
                check({tag, "_rdata_stall"}, RDATA, expd);
                check({tag, "_rlast_stall"}, R_LAST, b == nbeats - 1);
            end
            R_READY = 1;
            check({tag, "_rvalid"}, R_VALID, 1);
            check({tag, "_rdata"}, RDATA, expd);
            check({tag, "_rresp"}, RRESP, exp_resp);
            check({tag, "_rlast"}, R_LAST, b == nbeats - 1);
            check({tag, "_rid"}, R_ID, id);
            @(negedge clk);
        end
        R_READY = 0;
        check({tag, "_rvalid_done"}, R_VALID, 0);
        check({tag, "_arready_back"}, AR_READY, 1);
    endtask

    initial begin
        rst_n = 0;
        AW_VALID = 0; AW_ADDR = 0; AW_ID = 0; AW_LEN = 0; AW_SNOOP = 0;
        W_VALID = 0; W_LAST = 0; W_DATA = 0; B_READY = 0;
        AR_VALID = 0; AR_ADDR = 0; AR_ID = 0; AR_LEN = 0; AR_SNOOP = 0;
        R_READY = 0; peer_shared = 0;
        for (int i = 0; i < 256; i++) model[i] = 32'd0;
        #12;
        check("rst_arready", AR_READY, 1);
        check("rst_awready", AW_READY, 1);
        check("rst_rvalid", R_VALID, 0);
        check("rst_wready", W_READY, 0);
        check("rst_bvalid", B_VALID, 0);
        check("rst_rlast", R_LAST, 0);
        check("rst_rresp", RRESP, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_bresp", BRESP, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Basic write then read back at index 5.
        wr_burst("wb5", 32'h14, 8'd0, 3'b011, 1'b1, 32'hA5A5_0001, 0, 1'b1, 2'b00);
        rd_burst("rd5", 32'h14, 8'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1, 4'b0000, 1'b1);
        check("rd5_value", model[5], 32'hA5A5_0001);

        // Wrapping burst at the top of memory, read back shared with stalls.
        wr_burst("wwrap", 32'h3F8, 8'd3, 3'b000, 1'b0, 32'h0000_0100, 3, 1'b1, 2'b00);
        rd_burst("rshr", 32'h3F8, 8'd3, 4'b0001, 1'b1, 1'b0, 1'b1, 4, 4'b1000, 1'b1);

        // MakeUnique ignores AR_LEN.
        rd_burst("mu", 32'h3F8, 8'd7, 4'b1100, 1'b1, 1'b1, 1'b0, 1, 4'b0000, 1'b0);

        // Out-of-range write: DECERR, memory at index 0/1 untouched.
        wr_burst("wdec", 32'h0000_1000, 8'd1, 3'b000, 1'b1, 32'hDEAD_0000, 1, 1'b0, 2'b11);
        rd_burst("rchk0", 32'h0, 8'd1, 4'b0000, 1'b0, 1'b0, 1'b0, 2, 4'b0000, 1'b1);
        check("wdec_keep", model[0], 32'h0000_0102);

        // Unsupported read snoop.
        rd_burst("rbad", 32'h0, 8'd1, 4'b0111, 1'b0, 1'b1, 1'b0, 2, 4'b0010, 1'b0);

        // Early W_LAST: data still written, SLVERR.
        wr_burst("wlast", 32'h50, 8'd2, 3'b010, 1'b0, 32'h0000_0C00, 1, 1'b1, 2'b10);
        rd_burst("rlast", 32'h50, 8'd2, 4'b0000, 1'b0, 1'b0, 1'b0, 3, 4'b0000, 1'b1);

        // Same-cycle write and read to index 9: read returns old data.
        wr_burst("w9", 32'h24, 8'd0, 3'b000, 1'b0, 32'h1, 0, 1'b1, 2'b00);
        AW_VALID = 1; AW_ADDR = 32'h24; AW_LEN = 0; AW_SNOOP = 3'b000; AW_ID = 0;
        @(negedge clk);
        AW_VALID = 0;
        W_VALID = 1; W_DATA = 32'h2; W_LAST = 1;
        AR_VALID = 1; AR_ADDR = 32'h24; AR_LEN = 0; AR_SNOOP = 4'b0000; AR_ID = 0;
        R_READY = 0;
        @(negedge clk);
        W_VALID = 0; W_LAST = 0; AR_VALID = 0;
        check("coll_rvalid", R_VALID, 1);
        check("coll_rdata_old", RDATA, 32'h1);
        check("coll_bvalid", B_VALID, 1);
        check("coll_bresp", BRESP, 0);
        R_READY = 1; B_READY = 1;
        @(negedge clk);
        R_READY = 0; B_READY = 0;
        model[9] = 32'h2;
        rd_burst("r9new", 32'h24, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1, 4'b0000, 1'b1);

        // Reset during beat 2 of an 8-beat read.
        AR_VALID = 1; AR_ADDR = 32'h0; AR_LEN = 8'd7; AR_SNOOP = 4'b0000; AR_ID = 1;
        R_READY = 1;
        @(negedge clk);
        AR_VALID = 0;
        @(negedge clk);
        @(negedge clk);
        check("abort_rvalid_pre", R_VALID, 1);
        rst_n = 0;
        #1;
        check("abort_rvalid", R_VALID, 0);
        R_READY = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("abort_arready", AR_READY, 1);
        check("abort_rvalid_after", R_VALID, 0);
        rd_burst("rpost", 32'h14, 8'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1, 4'b0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
